mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
//  Issues loads/stores to data memory over a req/ack handshake and stalls upstream stages while waiting.
//  Selects the write-back value and registers all write-back controls for the WB stage.
// PARAMETERS
//  TIMEOUT  16  max WAIT cycles without dmem_ack before a bus error (>=1)
// PORTS
//  clk                 in   1   clock
//  rst                 in   1   reset, synchronous, active-high
//  mem_alu_out         in   32  address for memory ops; ALU result for write-back
//  mem_N               in   1   negative flag; write-back source for sel=11
//  mem_reg_data_2      in   32  store data
//  mem_mem_enable      in   1   memory op valid
//  mem_mem_read        in   1   load
//  mem_mem_write       in   1   store
//  mem_write_data_sel  in   2   write-back source select
//  mem_write_reg_sel   in   5   destination register
//  mem_write_reg_en    in   1   register write enable
//  mem_instruction     in   32  instruction (carried)
//  mem_PC_4            in   32  PC+4 (carried)
//  mem_HALT            in   1   halt marker
//  dmem_req            out  1   memory request
//  dmem_we             out  1   1 = write
//  dmem_addr           out  32  {mem_alu_out[31:2],2'b00}
//  dmem_wdata          out  32  = mem_reg_data_2
//  dmem_rdata          in   32  read data, valid in the dmem_ack cycle
//  dmem_ack            in   1   access complete (may be in the same cycle as req)
//  mem_stall           out  1   freeze PC/IF/ID/EX and EX/MEM registers
//  wb_write_data       out  32  registered write-back value
//  wb_write_reg_sel    out  5   registered
//  wb_write_reg_en     out  1   registered
//  wb_instruction      out  32  registered
//  wb_PC_4             out  32  registered
//  wb_HALT             out  1   registered
//  mem_err             out  1   sticky bus error flag
//  mem_err_addr        out  32  address of the first faulting access
// BEHAVIOUR
//  - mem_op = mem_mem_enable & (mem_mem_read | mem_mem_write).
//    dmem_we = mem_mem_write; write wins if read and write are both set.
//  - FSM states: IDLE, WAIT, ERR.
//  - IDLE
//    - mem_op & ~mem_err: dmem_req=1 combinationally.
//    - ack in the same cycle: complete, stay IDLE.
//    - no ack: go to WAIT, wait_cnt=1.
//  - WAIT
//    - dmem_req=1; addr/wdata stable because EX/MEM is stalled.
//    - ack: complete, go to IDLE.
//    - wait_cnt==TIMEOUT without ack: go to ERR, dmem_req=0.
//    - otherwise wait_cnt++.
//  - ERR (one cycle)
//    - mem_err<=1 (sticky until rst); mem_err_addr<=dmem_addr on the first error only.
//    - Instruction retires with wb_write_reg_en=0; then go to IDLE.
//  - While mem_err=1, later mem_ops are not issued (dmem_req=0); they retire immediately with write_reg_en forced 0.
//  - mem_stall = mem_op & ~mem_err & ~complete & (state!=ERR), where complete = dmem_ack while requesting.
//    - Zero-wait memory gives no stall.
//    - Each wait cycle adds one stall cycle.
//  - MEM/WB register loads every cycle.
//    - mem_stall=1: loads a bubble (wb_write_reg_en=0, wb_HALT=0, other wb_* don't-care/held).
//    - otherwise: loads the stage values.
//  - Write-back select:
//    - 00: mem_alu_out
//    - 01: dmem_rdata (sampled in the ack cycle)
//    - 10: mem_PC_4
//    - 11: {31'b0,mem_N}
//  - Reset values: state=IDLE, wait_cnt=0, all wb_*=0, mem_err=0, mem_err_addr=0.
//    dmem_req=0 in the cycle after rst is seen.
//  - rst mid-WAIT aborts the access; no write-back and no error.
//  - dmem_ack outside a request is ignored.
// CONFIGURATION
//  Macro MEM_ALIGN_CHECK_EN:
//  - Defined: a mem_op with mem_alu_out[1:0]!=0 is not issued (dmem_req=0).
//    It goes IDLE->ERR directly (same error actions; mem_stall=1 in the detect cycle).
//  - Undefined: addr[1:0] is ignored, and no check logic is built.
// TESTING
//  - Load, ack in the same cycle, sel=01, rdata=0xDEADBEEF, reg 5:
//    -> no stall; next cycle wb_write_data=0xDEADBEEF, wb_write_reg_sel=5, wb_write_reg_en=1.
//  - Store to 0x100, ack after 3 cycles:
//    -> dmem_req/we high for 4 cycles; mem_stall=1 for 3 cycles; 3 WB bubbles, then the store retires.
//  - Load, no ack, TIMEOUT=16:
//    -> req drops after 16 WAIT cycles; mem_err=1; mem_err_addr=address; wb_write_reg_en=0.
//    -> a following load is not issued.
//  - rst asserted in cycle 2 of WAIT:
//    -> next cycle dmem_req=0, mem_stall=0, all wb_*=0, mem_err=0.
//  - sel=10 with PC_4=0x44, and sel=11 with N=1, no mem_op:
//    -> wb_write_data=0x44, then 0x1; HALT=1 passes to wb_HALT one cycle later.
//  - MEM_ALIGN_CHECK_EN, load at 0x102:
//    -> no req; mem_err=1, mem_err_addr=0x100. Without the macro: req at 0x100.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: data-memory req/ack handshake with timeout, write-back select.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned accesses as bus errors.
module mem_wb_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_alu_out,
   input  logic        mem_N,
   input  logic [31:0] mem_reg_data_2,
   input  logic        mem_mem_enable,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic [1:0]  mem_write_data_sel,
   input  logic [4:0]  mem_write_reg_sel,
   input  logic        mem_write_reg_en,
   input  logic [31:0] mem_instruction,
   input  logic [31:0] mem_PC_4,
   input  logic        mem_HALT,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic [31:0] wb_write_data,
   output logic [4:0]  wb_write_reg_sel,
   output logic        wb_write_reg_en,
   output logic [31:0] wb_instruction,
   output logic [31:0] wb_PC_4,
   output logic        wb_HALT,
   output logic        mem_err,
   output logic [31:0] mem_err_addr
);

   localparam int             CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_CNT = CW'(TIMEOUT);
   localparam logic [CW-1:0]  ONE    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_ERR  = 2'b10
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_wait_cnt;
   logic [CW-1:0] w_wait_cnt_nxt;
   logic          r_mem_err;
   logic [31:0]   r_mem_err_addr;
   logic [31:0]   r_wb_write_data;
   logic [4:0]    r_wb_write_reg_sel;
   logic          r_wb_write_reg_en;
   logic [31:0]   r_wb_instruction;
   logic [31:0]   r_wb_PC_4;
   logic          r_wb_HALT;

   logic          w_mem_op;
   logic          w_misalign;
   logic          w_req;
   logic          w_complete;
   logic          w_stall;
   logic          w_retire_en;
   logic [31:0]   w_wb_data;

   assign w_mem_op = mem_mem_enable & (mem_mem_read | mem_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = (mem_alu_out[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   // Handshake FSM next state, wait counter and request strobe
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_req          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op && !r_mem_err) begin
               if (w_misalign) begin
                  w_state_nxt = S_ERR;
               end else begin
                  w_req = 1'b1;
                  if (!dmem_ack) begin
                     w_state_nxt    = S_WAIT;
                     w_wait_cnt_nxt = ONE;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            w_req = 1'b1;
            if (dmem_ack) begin
               w_state_nxt    = S_IDLE;
               w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt == TO_CNT) begin
               w_state_nxt    = S_ERR;
               w_wait_cnt_nxt = '0;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + ONE;
            end
         end
         S_ERR: begin
            w_state_nxt    = S_IDLE;
            w_wait_cnt_nxt = '0;
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_wait_cnt_nxt = '0;
         end
      endcase
   end

   assign w_complete = w_req & dmem_ack;
   assign w_stall    = w_mem_op & ~r_mem_err & ~w_complete & (r_state != S_ERR);
   // A faulting access, or any access after the sticky error, must not write a register
   assign w_retire_en = mem_write_reg_en & (r_state != S_ERR) & ~(w_mem_op & r_mem_err);

   // Write-back source select
   always_comb begin
      w_wb_data = mem_alu_out;
      case (mem_write_data_sel)
         2'b00:   w_wb_data = mem_alu_out;
         2'b01:   w_wb_data = dmem_rdata;
         2'b10:   w_wb_data = mem_PC_4;
         2'b11:   w_wb_data = {31'b0, mem_N};
         default: w_wb_data = mem_alu_out;
      endcase
   end

   // FSM state and wait counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Sticky bus-error flag; address captured only for the first fault
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_err      <= 1'b0;
         r_mem_err_addr <= 32'h0;
      end else if (r_state == S_ERR) begin
         r_mem_err <= 1'b1;
         if (!r_mem_err) begin
            r_mem_err_addr <= dmem_addr;
         end
      end
   end

   // MEM/WB pipeline register: bubble while stalled, stage values otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_write_data    <= 32'h0;
         r_wb_write_reg_sel <= 5'd0;
         r_wb_write_reg_en  <= 1'b0;
         r_wb_instruction   <= 32'h0;
         r_wb_PC_4          <= 32'h0;
         r_wb_HALT          <= 1'b0;
      end else if (w_stall) begin
         r_wb_write_reg_en  <= 1'b0;
         r_wb_HALT          <= 1'b0;
      end else begin
         r_wb_write_data    <= w_wb_data;
         r_wb_write_reg_sel <= mem_write_reg_sel;
         r_wb_write_reg_en  <= w_retire_en;
         r_wb_instruction   <= mem_instruction;
         r_wb_PC_4          <= mem_PC_4;
         r_wb_HALT          <= mem_HALT;
      end
   end

   assign dmem_req         = w_req;
   assign dmem_we          = mem_mem_write;
   assign dmem_addr        = {mem_alu_out[31:2], 2'b00};
   assign dmem_wdata       = mem_reg_data_2;
   assign mem_stall        = w_stall;
   assign mem_err          = r_mem_err;
   assign mem_err_addr     = r_mem_err_addr;
   assign wb_write_data    = r_wb_write_data;
   assign wb_write_reg_sel = r_wb_write_reg_sel;
   assign wb_write_reg_en  = r_wb_write_reg_en;
   assign wb_instruction   = r_wb_instruction;
   assign wb_PC_4          = r_wb_PC_4;
   assign wb_HALT          = r_wb_HALT;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: expected MEM/WB contents are queued per cycle and compared one clock later.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic [31:0] mem_alu_out;
   logic        mem_N;
   logic [31:0] mem_reg_data_2;
   logic        mem_mem_enable;
   logic        mem_mem_read;
   logic        mem_mem_write;
   logic [1:0]  mem_write_data_sel;
   logic [4:0]  mem_write_reg_sel;
   logic        mem_write_reg_en;
   logic [31:0] mem_instruction;
   logic [31:0] mem_PC_4;
   logic        mem_HALT;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        mem_stall;
   logic [31:0] wb_write_data;
   logic [4:0]  wb_write_reg_sel;
   logic        wb_write_reg_en;
   logic [31:0] wb_instruction;
   logic [31:0] wb_PC_4;
   logic        wb_HALT;
   logic        mem_err;
   logic [31:0] mem_err_addr;

   typedef struct {
      logic        chk_data;
      logic        en;
      logic [31:0] data;
      logic [4:0]  sel;
      logic        halt;
   } wb_t;

   wb_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;

   mem_wb_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_alu_out(mem_alu_out), .mem_N(mem_N), .mem_reg_data_2(mem_reg_data_2),
      .mem_mem_enable(mem_mem_enable), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_write_data_sel(mem_write_data_sel), .mem_write_reg_sel(mem_write_reg_sel),
      .mem_write_reg_en(mem_write_reg_en), .mem_instruction(mem_instruction),
      .mem_PC_4(mem_PC_4), .mem_HALT(mem_HALT),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
      .wb_write_data(wb_write_data), .wb_write_reg_sel(wb_write_reg_sel),
      .wb_write_reg_en(wb_write_reg_en), .wb_instruction(wb_instruction),
      .wb_PC_4(wb_PC_4), .wb_HALT(wb_HALT), .mem_err(mem_err), .mem_err_addr(mem_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic wb_t mk(input logic c, input logic en, input logic [31:0] d,
                              input logic [4:0] s, input logic h);
      wb_t w;
      w.chk_data = c; w.en = en; w.data = d; w.sel = s; w.halt = h;
      return w;
   endfunction

   task automatic clr_inputs();
      mem_alu_out = 32'h0; mem_N = 1'b0; mem_reg_data_2 = 32'h0;
      mem_mem_enable = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
      mem_write_data_sel = 2'b00; mem_write_reg_sel = 5'd0; mem_write_reg_en = 1'b0;
      mem_instruction = 32'h0; mem_PC_4 = 32'h0; mem_HALT = 1'b0;
      dmem_rdata = 32'h0; dmem_ack = 1'b0;
   endtask

   task automatic set_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [1:0] dsel, input logic [4:0] rsel, input logic ren);
      mem_mem_enable = rd | wr; mem_mem_read = rd; mem_mem_write = wr;
      mem_alu_out = addr; mem_write_data_sel = dsel;
      mem_write_reg_sel = rsel; mem_write_reg_en = ren;
   endtask

   // Inputs must already be settled; checks the combinational outputs, clocks once, checks MEM/WB.
   task automatic cycle(input string tag, input logic chk_comb, input logic exp_req,
                        input logic exp_stall, input wb_t exp);
      wb_t e;
      if (chk_comb) begin
         chk_val({tag, ".req"}, {31'b0, dmem_req}, {31'b0, exp_req});
         chk_val({tag, ".stall"}, {31'b0, mem_stall}, {31'b0, exp_stall});
      end
      sb.push_back(exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_val({tag, ".wb_en"}, {31'b0, wb_write_reg_en}, {31'b0, e.en});
      chk_val({tag, ".wb_halt"}, {31'b0, wb_HALT}, {31'b0, e.halt});
      if (e.chk_data) begin
         chk_val({tag, ".wb_data"}, wb_write_data, e.data);
         chk_val({tag, ".wb_sel"}, {27'b0, wb_write_reg_sel}, {27'b0, e.sel});
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clr_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      wb_t bub;
      bub = mk(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
      clr_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_val("rst.wb_data", wb_write_data, 32'h0);
      chk_val("rst.wb_en", {31'b0, wb_write_reg_en}, 32'h0);
      chk_val("rst.wb_instr", wb_instruction, 32'h0);
      chk_val("rst.wb_pc4", wb_PC_4, 32'h0);
      chk_val("rst.err", {31'b0, mem_err}, 32'h0);
      chk_val("rst.err_addr", mem_err_addr, 32'h0);
      chk_val("rst.req", {31'b0, dmem_req}, 32'h0);

      // Zero-wait load
      set_op(1'b1, 1'b0, 32'h0000_0200, 2'b01, 5'd5, 1'b1);
      mem_instruction = 32'h1234_0005; mem_PC_4 = 32'h0000_0010;
      dmem_rdata = 32'hDEAD_BEEF; dmem_ack = 1'b1;
      #1;
      chk_val("ld.we", {31'b0, dmem_we}, 32'h0);
      chk_val("ld.addr", dmem_addr, 32'h0000_0200);
      cycle("ld", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd5, 1'b0));
      chk_val("ld.wb_instr", wb_instruction, 32'h1234_0005);
      chk_val("ld.wb_pc4", wb_PC_4, 32'h0000_0010);

      // Store to 0x100, three wait cycles; HALT rides along to check bubbles suppress it
      clr_inputs();
      set_op(1'b0, 1'b1, 32'h0000_0100, 2'b00, 5'd0, 1'b0);
      mem_reg_data_2 = 32'h1234_5678; mem_HALT = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk_val("st.we", {31'b0, dmem_we}, 32'h1);
         chk_val("st.wdata", dmem_wdata, 32'h1234_5678);
         cycle("st_wait", 1'b1, 1'b1, 1'b1, bub);
      end
      dmem_ack = 1'b1;
      #1;
      cycle("st_done", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 32'h0000_0100, 5'd0, 1'b1));

      // Read and write both set: write wins
      clr_inputs();
      set_op(1'b1, 1'b1, 32'h0000_0300, 2'b00, 5'd1, 1'b0);
      dmem_ack = 1'b1;
      #1;
      chk_val("rw.we", {31'b0, dmem_we}, 32'h1);
      cycle("rw", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b0, 32'h0000_0300, 5'd1, 1'b0));

      // Non-memory write-back sources
      clr_inputs();
      mem_write_data_sel = 2'b10; mem_PC_4 = 32'h44; mem_write_reg_sel = 5'd3; mem_write_reg_en = 1'b1;
      #1;
      cycle("pc4", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h44, 5'd3, 1'b0));
      mem_write_data_sel = 2'b11; mem_N = 1'b1; mem_write_reg_sel = 5'd4; mem_HALT = 1'b1;
      #1;
      cycle("negN", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h1, 5'd4, 1'b1));
      mem_write_data_sel = 2'b00; mem_alu_out = 32'hCAFE_F00D; mem_HALT = 1'b0; mem_write_reg_sel = 5'd31;
      #1;
      cycle("alu", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'hCAFE_F00D, 5'd31, 1'b0));

      // Stray ack with no request changes nothing
      clr_inputs();
      dmem_ack = 1'b1; mem_alu_out = 32'h10; mem_write_reg_en = 1'b1; mem_write_reg_sel = 5'd6;
      #1;
      cycle("stray_ack", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h10, 5'd6, 1'b0));
      clr_inputs();
      set_op(1'b1, 1'b0, 32'h0000_0020, 2'b01, 5'd8, 1'b1);
      dmem_rdata = 32'h0BAD_F00D; dmem_ack = 1'b1;
      #1;
      cycle("after_stray", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h0BAD_F00D, 5'd8, 1'b0));

      // Misaligned load at 0x102
      clr_inputs();
      set_op(1'b1, 1'b0, 32'h0000_0102, 2'b01, 5'd7, 1'b1);
      dmem_rdata = 32'h55; dmem_ack = 1'b1;
      #1;
`ifdef MEM_ALIGN_CHECK_EN
      cycle("mis_det", 1'b1, 1'b0, 1'b1, bub);
      cycle("mis_err", 1'b1, 1'b0, 1'b0, bub);
      chk_val("mis.err", {31'b0, mem_err}, 32'h1);
      chk_val("mis.err_addr", mem_err_addr, 32'h0000_0100);
`else
      chk_val("mis.addr", dmem_addr, 32'h0000_0100);
      cycle("mis", 1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h55, 5'd7, 1'b0));
      chk_val("mis.err", {31'b0, mem_err}, 32'h0);
`endif
      apply_reset();

      // Reset in the second WAIT cycle aborts the access
      set_op(1'b1, 1'b0, 32'h0000_0300, 2'b01, 5'd9, 1'b1);
      mem_instruction = 32'hAAAA_0001; mem_PC_4 = 32'h0000_0040;
      #1;
      cycle("rw_idle", 1'b1, 1'b1, 1'b1, bub);
      cycle("rw_wait1", 1'b1, 1'b1, 1'b1, bub);
      rst = 1'b1;
      cycle("rw_rst", 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h0, 5'd0, 1'b0));
      chk_val("rw_rst.wb_instr", wb_instruction, 32'h0);
      chk_val("rw_rst.wb_pc4", wb_PC_4, 32'h0);
      chk_val("rw_rst.err", {31'b0, mem_err}, 32'h0);
      rst = 1'b0;
      clr_inputs();
      #1;
      cycle("rw_after", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h0, 5'd0, 1'b0));

      // Timeout: 1 issue cycle + 16 WAIT cycles, then ERR
      set_op(1'b1, 1'b0, 32'h0000_0400, 2'b01, 5'd9, 1'b1);
      #1;
      cycle("to_issue", 1'b1, 1'b1, 1'b1, bub);
      for (int i = 1; i <= 16; i++) begin
         cycle("to_wait", 1'b1, 1'b1, 1'b1, bub);
      end
      chk_val("to.err_pre", {31'b0, mem_err}, 32'h0);
      cycle("to_err", 1'b1, 1'b0, 1'b0, bub);
      chk_val("to.err", {31'b0, mem_err}, 32'h1);
      chk_val("to.err_addr", mem_err_addr, 32'h0000_0400);

      // Loads after the error are not issued and retire without a write
      clr_inputs();
      set_op(1'b1, 1'b0, 32'h0000_0500, 2'b01, 5'd10, 1'b1);
      dmem_ack = 1'b1; dmem_rdata = 32'h77;
      #1;
      cycle("post_ld", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h77, 5'd10, 1'b0));
      clr_inputs();
      mem_alu_out = 32'h0000_0077; mem_write_reg_sel = 5'd2; mem_write_reg_en = 1'b1;
      #1;
      cycle("post_alu", 1'b1, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h77, 5'd2, 1'b0));
      chk_val("post.err_addr", mem_err_addr, 32'h0000_0400);
      chk_val("post.err", {31'b0, mem_err}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
